// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Signed operations run on magnitudes; sign correction is applied on the
// edge that writes HI/LO, so partial results never reach the outputs.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  state_t               state_q;
  logic                 busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic [CNTW-1:0]      cnt_q;
  // Shared datapath: MUL keeps {partial product, multiplier}; DIV keeps {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;
  logic                 neg_lo_q, neg_hi_q;

  logic                 op_signed;
  logic [WIDTH-1:0]     abs0, abs1;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix;

  // One shift-add / restoring-divide step plus sign-corrected final results.
  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    abs0      = (op_signed && src0[WIDTH-1]) ? -src0 : src0;
    abs1      = (op_signed && src1[WIDTH-1]) ? -src1 : src1;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (!div_diff[WIDTH]) begin
      div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod_fix  = neg_lo_q ? -mul_step : mul_step;
    q_fix     = neg_lo_q ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
    r_fix     = neg_hi_q ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered busy/done/flag outputs and HI/LO write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state_q  <= MUL;
                busy_q   <= 1'b1;
                dbz_q    <= 1'b0;
                cnt_q    <= CNTW'(WIDTH);
                acc_q    <= (2*WIDTH)'(abs1);
                opb_q    <= abs0;
                neg_lo_q <= op_signed && (src0[WIDTH-1] ^ src1[WIDTH-1]);
              end
              OP_DIV, OP_DIVU: begin
                if (src1 == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  dbz_q   <= 1'b1;
                end else begin
                  state_q  <= DIV;
                  busy_q   <= 1'b1;
                  dbz_q    <= 1'b0;
                  cnt_q    <= CNTW'(WIDTH);
                  acc_q    <= (2*WIDTH)'(abs0);
                  opb_q    <= abs1;
                  neg_lo_q <= op_signed && (src0[WIDTH-1] ^ src1[WIDTH-1]);
                  neg_hi_q <= op_signed && src0[WIDTH-1];
                end
              end
              OP_MTHI: begin
                hi_q    <= src0;
                state_q <= DONE;
                done_q  <= 1'b1;
                dbz_q   <= 1'b0;
              end
              OP_MTLO: begin
                lo_q    <= src0;
                state_q <= DONE;
                done_q  <= 1'b1;
                dbz_q   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc_q <= mul_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) begin
            {hi_q, lo_q} <= prod_fix;
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        DIV: begin
          acc_q <= div_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) begin
            hi_q    <= r_fix;
            lo_q    <= q_fix;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed vector table,
// randomized operations against an arithmetic reference, and corner sequences.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src0, src1;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mhi, mlo;
  logic         mdbz;

  alu_muldiv #(.WIDTH(W), .CNTW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src0(src0), .src1(src1), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural results.
  task automatic ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
    longint      sa, sb, q, r;
    logic [63:0] p;
    eh = mhi; el = mlo; ed = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      3'd1: begin p = 64'(a) * 64'(b); eh = p[63:32]; el = p[31:0]; end
      3'd2: if (b == 0) ed = 1'b1;
            else begin
              q = sa / sb; r = sa % sb;
              p = 64'(q); el = p[31:0];
              p = 64'(r); eh = p[31:0];
            end
      3'd3: if (b == 0) ed = 1'b1; else begin el = a / b; eh = a % b; end
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endtask

  // Issue one accepted operation and check latency, busy span, results and flag.
  task automatic exec_op(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input logic ed);
    bit           iter;
    int           done_cyc, busy_cnt, stale;
    logic [W-1:0] hi_at, lo_at;
    logic         dbz_at;
    iter = (o <= 3'd1) || ((o == 3'd2 || o == 3'd3) && b != 0);
    @(negedge clk);
    start = 1'b1; op = o; src0 = a; src1 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 5)); src0 = $urandom; src1 = $urandom;
    done_cyc = 0; busy_cnt = 0; stale = 0;
    hi_at = 'x; lo_at = 'x; dbz_at = 1'bx;
    for (int k = 1; k <= W + 4 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && (hi !== mhi || lo !== mlo)) stale++;
      if (done) begin done_cyc = k; hi_at = hi; lo_at = lo; dbz_at = dbz; end
    end
    check({nm, " done_cycle"}, 64'(done_cyc), iter ? 64'(W + 1) : 64'd1);
    check({nm, " busy_cycles"}, 64'(busy_cnt), iter ? 64'(W) : 64'd0);
    check({nm, " hi"}, 64'(hi_at), 64'(eh));
    check({nm, " lo"}, 64'(lo_at), 64'(el));
    check({nm, " dbz"}, 64'(dbz_at), 64'(ed));
    check({nm, " hilo_stable_while_busy"}, 64'(stale), 64'd0);
    @(negedge clk);
    check({nm, " done_one_cycle"}, {62'd0, done, busy}, 64'd0);
    mhi = eh; mlo = el; mdbz = ed;
  endtask

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] a, b, eh, el;
    logic         ed;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [W-1:0] eh, el;
    logic         ed;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    int           dc, seen;

    vt[0] = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vt[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[2] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vt[3] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[4] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
    vt[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[6] = '{3'd4, 32'hAAAAAAAA, 32'h00000000, 32'hAAAAAAAA, 32'h80000000, 1'b0};
    vt[7] = '{3'd5, 32'h55555555, 32'h00000000, 32'hAAAAAAAA, 32'h55555555, 1'b0};
    vt[8] = '{3'd3, 32'h00000007, 32'h00000000, 32'hAAAAAAAA, 32'h55555555, 1'b1};
    vt[9] = '{3'd5, 32'h00000001, 32'h00000000, 32'hAAAAAAAA, 32'h00000001, 1'b0};

    reset = 1'b1; start = 1'b0; op = '0; src0 = '0; src1 = '0;
    #2 reset = 1'b0;
    #1;
    check("reset_outputs", {busy, done, dbz, hi, lo}, 67'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    mhi = '0; mlo = '0; mdbz = 1'b0;

    for (int i = 0; i < 10; i++) begin
      exec_op($sformatf("vec%0d", i), vt[i].o, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, vt[i].ed);
    end

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) rb = '0;
      ref_op(ro, ra, rb, eh, el, ed);
      exec_op($sformatf("rand%0d", i), ro, ra, rb, eh, el, ed);
    end

    // MTHI arriving mid-MULT must be dropped.
    @(negedge clk);
    start = 1'b1; op = 3'd0; src0 = 32'd7; src1 = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd4; src0 = 32'hDEADBEEF;
    @(posedge clk); #1 start = 1'b0;
    dc = 0;
    for (int k = 5; k <= W + 4 && dc == 0; k++) begin
      @(negedge clk);
      if (done) dc = k;
    end
    check("mthi_ignored done_cycle", 64'(dc), 64'(W + 1));
    check("mthi_ignored hi", 64'(hi), 64'h0);
    check("mthi_ignored lo", 64'(lo), 64'd63);
    mhi = '0; mlo = 32'd63; mdbz = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (done || busy) seen++; end
    check("mthi_ignored no_followup", 64'(seen), 64'd0);

    // Reserved op codes do nothing.
    for (int r = 6; r <= 7; r++) begin
      @(negedge clk);
      start = 1'b1; op = 3'(r); src0 = $urandom; src1 = 32'd1;
      @(posedge clk); #1 start = 1'b0;
      seen = 0;
      repeat (4) begin @(negedge clk); if (done || busy) seen++; end
      check($sformatf("reserved%0d no_activity", r), 64'(seen), 64'd0);
      check($sformatf("reserved%0d hilo", r), {hi, lo}, {mhi, mlo});
    end

    // Asynchronous reset in the middle of a DIV.
    exec_op("pre_mthi", 3'd4, 32'h12345678, 32'd0, 32'h12345678, mlo, 1'b0);
    exec_op("pre_mtlo", 3'd5, 32'h9ABCDEF0, 32'd0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; src0 = 32'd1000; src1 = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("div_running_before_reset", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("midreset outputs", {busy, done, dbz, hi, lo}, 67'd0);
    seen = 0;
    repeat (3) begin @(negedge clk); if (done || busy) seen++; end
    check("midreset no_done", 64'(seen), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    mhi = '0; mlo = '0; mdbz = 1'b0;
    exec_op("post_reset_mult", 3'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width (even, >=8).
REQ-002 SHALL have parameter CNTW, default 6: iteration counter width, >= clog2(WIDTH)+1.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request; sampled on rising clk edge.
REQ-006 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-007 SHALL have port src0  input  WIDTH  multiplicand / dividend / move data.
REQ-008 SHALL have port src1  input  WIDTH  multiplier / divisor.
REQ-009 SHALL have port busy  output  1  iterative operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port hi  output  WIDTH  HI register.
REQ-012 SHALL have port lo  output  WIDTH  LO register.
REQ-013 SHALL have port div_by_zero  output  1  sticky flag for last DIV/DIVU; cleared by next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-015 SHALL accept start only in IDLE; in MUL, DIV or DONE, start is ignored without side effects.
REQ-016 SHALL ignore reserved op codes: no state change, no done, no register update.
REQ-017 SHALL, for MULT/MULTU accepted at edge T, go IDLE->MUL, iterate shift-add one bit per cycle for WIDTH cycles (T+1..T+WIDTH), enter DONE, and present the product in cycle T+WIDTH+1.
REQ-018 SHALL, for DIV/DIVU with src1 != 0 accepted at edge T, go IDLE->DIV, run restoring division one quotient bit per cycle for WIDTH cycles, and present the result in cycle T+WIDTH+1.
REQ-019 SHALL latch src0, src1 and op at acceptance; input changes during busy have no effect.
REQ-020 SHALL perform signed ops on magnitudes with sign correction: MULT gives the 2*WIDTH-bit two's-complement product {hi,lo}; MULTU gives the unsigned product.
REQ-021 SHALL make DIV quotient (lo) truncate toward zero and remainder (hi) carry the dividend sign; DIVU is unsigned.
REQ-022 SHALL give DIV of most-negative by -1: lo = most-negative (wrap), hi = 0, no error flag.
REQ-023 SHALL, on DIV/DIVU with src1 == 0: leave hi/lo unchanged, set div_by_zero, never assert busy, go IDLE->DONE with done in cycle T+1.
REQ-024 SHALL make MTHI/MTLO write src0 into hi/lo at edge T, never assert busy, and pulse done in cycle T+1 via DONE.
REQ-025 SHALL assert busy exactly in MUL and DIV; done exactly in DONE; DONE returns to IDLE after one cycle.
REQ-026 SHALL update hi/lo only on the edge entering DONE (MUL/DIV) or the accepting edge (MTHI/MTLO); intermediate values never appear on hi/lo.
REQ-027 SHALL use only registered outputs (no combinational input-to-output path).

Reset
REQ-028 SHALL, on reset low at any time, asynchronously force state IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0, aborting any operation in progress.
REQ-029 SHALL accept a start on the first rising edge after reset deasserts.

Verification (WIDTH=32)
REQ-030 SHALL verify MULT src0=FFFFFFFD, src1=00000005 at edge T -> busy cycles T+1..T+32, done cycle T+33, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-031 SHALL verify MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; MULT same operands -> hi=00000000, lo=00000001.
REQ-032 SHALL verify DIV FFFFFFF9/00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU same -> lo=7FFFFFFC, hi=00000001; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-033 SHALL verify DIVU 7/0 with hi=AAAAAAAA, lo=55555555 -> done cycle T+1, busy never high, div_by_zero=1, hi/lo unchanged; next MTLO 00000001 -> div_by_zero=0, lo=00000001, done T+1.
REQ-034 SHALL verify start with MTHI pulsed at cycle T+5 of a MULT -> ignored, hi equals product; reserved op 110 -> no done.
REQ-035 SHALL verify reset low at cycle T+10 of a DIV -> immediately busy=0, hi=lo=0; no done; new MULT 2*3 after release -> lo=00000006 at T'+33.
